row_permute_engine: RTL and testbench

- Parametrised row-scrambling engine for the image-encryption datapath.
- Streams an image row by row from external 16-bit SRAM, reads a chaotic permutation key from a key region of the same SRAM, permutes pixels within each row, and writes the row to a destination region.
- Differs from the fixed 128-pixel column rearranger:
  - generic row width, pixel width and row count;
  - encrypt/decrypt mode (forward or inverse permutation);
  - key cached once or reloaded per row;
  - start/busy/done handshake.

---
 rtl/row_permute_engine_pkg.sv | 53 +++++
 rtl/row_permute_engine_if.sv | 38 +++
 rtl/row_permute_engine_buf.sv | 48 ++++
 rtl/row_permute_engine.sv | 168 ++++++++++++++++
 tb/tb_row_permute_engine.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/row_permute_engine_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_perm_pkg: shared types, strobe encodings and derived constants   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package row_perm_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_KEY_RD   = 4'd1,
    S_KEY_CAP  = 4'd2,
    S_ROW_RD   = 4'd3,
    S_ROW_CAP  = 4'd4,
    S_PERMUTE  = 4'd5,
    S_WR       = 4'd6,
    S_WR_END   = 4'd7,
    S_NEXT_ROW = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  // SRAM strobe set for each bus phase
  typedef struct packed {
    logic oe_n;
    logic we_n;
    logic dout_en;
  } strobe_t;

  localparam strobe_t STB_IDLE   = 3'b110;
  localparam strobe_t STB_READ   = 3'b010;
  localparam strobe_t STB_WRITE  = 3'b101;
  localparam strobe_t STB_WR_END = 3'b111;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  function automatic int ppw(input int word_w, input int pix_w);
    return word_w / pix_w;
  endfunction

  function automatic int wpr(input int pix_per_row, input int word_w, input int pix_w);
    return pix_per_row / ppw(word_w, pix_w);
  endfunction

  function automatic int iw(input int pix_per_row);
    return clog2(pix_per_row);
  endfunction

endpackage
`default_nettype wire

// File: rtl/row_permute_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_permute_engine_if: control handshake and SRAM bus bundle         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface row_permute_engine_if #(
  parameter int ADDR_W = 18,
  parameter int WORD_W = 16,
  parameter int ROW_W  = 9
);
  logic              start;
  logic              mode;
  logic              busy;
  logic              done;
  logic [ROW_W-1:0]  row_idx;
  logic [ADDR_W-1:0] sram_addr;
  logic [WORD_W-1:0] sram_din;
  logic [WORD_W-1:0] sram_dout;
  logic              sram_dout_en;
  logic              sram_ce_n;
  logic              sram_lb_n;
  logic              sram_ub_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport master (
    output start, mode, sram_din,
    input  busy, done, row_idx, sram_addr, sram_dout, sram_dout_en,
           sram_ce_n, sram_lb_n, sram_ub_n, sram_oe_n, sram_we_n
  );

  modport slave (
    input  start, mode, sram_din,
    output busy, done, row_idx, sram_addr, sram_dout, sram_dout_en,
           sram_ce_n, sram_lb_n, sram_ub_n, sram_oe_n, sram_we_n
  );
endinterface
`default_nettype wire

// File: rtl/row_permute_engine_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perm_row_buf: input/output pixel arrays with unpack, permute, pack   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module perm_row_buf
  import row_perm_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int WORD_W      = 16,
  parameter int PIX_PER_ROW = 128
) (
  input  logic                         clk,
  input  logic                         wr_en_i,
  input  logic [iw(PIX_PER_ROW)-1:0]   wr_idx_i,
  input  logic [WORD_W-1:0]            wr_word_i,
  input  logic                         perm_en_i,
  input  logic [iw(PIX_PER_ROW)-1:0]   perm_src_i,
  input  logic [iw(PIX_PER_ROW)-1:0]   perm_dst_i,
  input  logic [iw(PIX_PER_ROW)-1:0]   rd_idx_i,
  output logic [WORD_W-1:0]            rd_word_o
);
  localparam int PPW = ppw(WORD_W, PIX_W);
  localparam int IW  = iw(PIX_PER_ROW);

  logic [PIX_W-1:0] in_buf_q  [PIX_PER_ROW];
  logic [PIX_W-1:0] out_buf_q [PIX_PER_ROW];

  // Contents survive reset; every slot is rewritten before it is read
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int k = 0; k < PPW; k++) begin
        in_buf_q[IW'(32'(wr_idx_i) * PPW + k)] <= wr_word_i[k*PIX_W +: PIX_W];
      end
    end
    if (perm_en_i) begin
      out_buf_q[perm_dst_i] <= in_buf_q[perm_src_i];
    end
  end

  always_comb begin
    rd_word_o = '0;
    for (int k = 0; k < PPW; k++) begin
      rd_word_o[k*PIX_W +: PIX_W] = out_buf_q[IW'(32'(rd_idx_i) * PPW + k)];
    end
  end
endmodule
`default_nettype wire

// File: rtl/row_permute_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_permute_engine: streams rows from SRAM, permutes them by a key   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module row_permute_engine
  import row_perm_pkg::*;
#(
  parameter int               PIX_W       = 8,
  parameter int               WORD_W      = 16,
  parameter int               PIX_PER_ROW = 128,
  parameter int               NUM_ROWS    = 384,
  parameter int               ADDR_W      = 18,
  parameter logic [ADDR_W-1:0] SRC_BASE   = 18'h0,
  parameter logic [ADDR_W-1:0] KEY_BASE   = 18'hC100,
  parameter logic [ADDR_W-1:0] DST_BASE   = 18'hC500,
  parameter bit               KEY_PER_ROW = 1'b0
) (
  input logic                clk,
  input logic                reset,
  row_permute_engine_if.slave bus
);
  localparam int P     = PIX_PER_ROW;
  localparam int WPR   = wpr(PIX_PER_ROW, WORD_W, PIX_W);
  localparam int IW    = iw(PIX_PER_ROW);
  localparam int ROW_W = clog2(NUM_ROWS);

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  strobe_t           stb_q, stb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IW-1:0]     key_buf_q [P];
  logic [ADDR_W-1:0] w_row_off;
  logic [IW-1:0]     w_key;
  logic [WORD_W-1:0] w_pack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      row_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      stb_q   <= STB_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_KEY_CAP) key_buf_q[cnt_q] <= bus.sram_din[IW-1:0];
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_KEY_RD;
        mode_d  = bus.mode;
        row_d   = '0;
        cnt_d   = '0;
      end
      S_KEY_RD:  state_d = S_KEY_CAP;
      S_KEY_CAP: begin
        state_d = (cnt_q == IW'(P-1)) ? S_ROW_RD : S_KEY_RD;
        cnt_d   = (cnt_q == IW'(P-1)) ? '0 : cnt_q + IW'(1);
      end
      S_ROW_RD:  state_d = S_ROW_CAP;
      S_ROW_CAP: begin
        state_d = (cnt_q == IW'(WPR-1)) ? S_PERMUTE : S_ROW_RD;
        cnt_d   = (cnt_q == IW'(WPR-1)) ? '0 : cnt_q + IW'(1);
      end
      S_PERMUTE: begin
        state_d = (cnt_q == IW'(P-1)) ? S_WR : S_PERMUTE;
        cnt_d   = (cnt_q == IW'(P-1)) ? '0 : cnt_q + IW'(1);
      end
      S_WR:      state_d = S_WR_END;
      S_WR_END: begin
        state_d = (cnt_q == IW'(WPR-1)) ? S_NEXT_ROW : S_WR;
        cnt_d   = (cnt_q == IW'(WPR-1)) ? '0 : cnt_q + IW'(1);
      end
      S_NEXT_ROW: begin
        cnt_d = '0;
        if (row_q == ROW_W'(NUM_ROWS-1)) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = KEY_PER_ROW ? S_KEY_RD : S_ROW_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        row_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Address and strobes are registered from the next state so they line up with it
    w_row_off = ADDR_W'(row_d) * ADDR_W'(WPR);
    addr_d    = addr_q;
    stb_d     = STB_IDLE;
    case (state_d)
      S_KEY_RD: begin
        addr_d = KEY_BASE + (KEY_PER_ROW ? ADDR_W'(row_d) * ADDR_W'(P) : '0) + ADDR_W'(cnt_d);
        stb_d  = STB_READ;
      end
      S_ROW_RD: begin
        addr_d = SRC_BASE + w_row_off + ADDR_W'(cnt_d);
        stb_d  = STB_READ;
      end
      S_WR: begin
        addr_d = DST_BASE + w_row_off + ADDR_W'(cnt_d);
        stb_d  = STB_WRITE;
      end
      S_WR_END: stb_d = STB_WR_END;
      default:  stb_d = STB_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign w_key = key_buf_q[cnt_q];

  perm_row_buf #(
    .PIX_W       (PIX_W),
    .WORD_W      (WORD_W),
    .PIX_PER_ROW (PIX_PER_ROW)
  ) u_buf (
    .clk        (clk),
    .wr_en_i    (state_q == S_ROW_CAP),
    .wr_idx_i   (cnt_q),
    .wr_word_i  (bus.sram_din),
    .perm_en_i  (state_q == S_PERMUTE),
    .perm_src_i (mode_q ? cnt_q : w_key),
    .perm_dst_i (mode_q ? w_key : cnt_q),
    .rd_idx_i   (cnt_q),
    .rd_word_o  (w_pack)
  );

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.row_idx      = row_q;
  assign bus.sram_addr    = addr_q;
  assign bus.sram_dout    = stb_q.dout_en ? w_pack : '0;
  assign bus.sram_dout_en = stb_q.dout_en;
  assign bus.sram_oe_n    = stb_q.oe_n;
  assign bus.sram_we_n    = stb_q.we_n;
  assign bus.sram_ce_n    = 1'b0;
  assign bus.sram_lb_n    = 1'b0;
  assign bus.sram_ub_n    = 1'b0;
endmodule
`default_nettype wire

// File: tb/tb_row_permute_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_row_permute_engine: directed checks with a behavioural SRAM       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_row_permute_engine;
  import row_perm_pkg::*;

  localparam int          ROW_W = clog2(2);
  localparam logic [17:0] SRC   = 18'h0;
  localparam logic [17:0] KEY   = 18'hC100;
  localparam logic [17:0] DST   = 18'hC500;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  row_permute_engine_if #(.ADDR_W(18), .WORD_W(16), .ROW_W(ROW_W)) ifa ();
  row_permute_engine_if #(.ADDR_W(18), .WORD_W(16), .ROW_W(ROW_W)) ifb ();

  row_permute_engine #(
    .PIX_W(8), .WORD_W(16), .PIX_PER_ROW(8), .NUM_ROWS(2), .ADDR_W(18),
    .SRC_BASE(SRC), .KEY_BASE(KEY), .DST_BASE(DST), .KEY_PER_ROW(1'b0)
  ) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));

  row_permute_engine #(
    .PIX_W(8), .WORD_W(16), .PIX_PER_ROW(8), .NUM_ROWS(2), .ADDR_W(18),
    .SRC_BASE(SRC), .KEY_BASE(KEY), .DST_BASE(DST), .KEY_PER_ROW(1'b1)
  ) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  bit   [15:0] mem_a [0:262143];
  bit   [15:0] mem_b [0:262143];
  logic        h_we_a = 1'b0;
  logic        h_we_b = 1'b0;
  logic [17:0] h_addr = '0;
  logic [15:0] h_data = '0;

  assign ifa.sram_din = mem_a[ifa.sram_addr];
  assign ifb.sram_din = mem_b[ifb.sram_addr];

  int cyc = 0, t_row0 = 0, t_row1 = 0, done_cnt_a = 0, done_cnt_b = 0;
  bit seen_k0 = 1'b0, seen_k1 = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!ifa.sram_we_n) mem_a[ifa.sram_addr] <= ifa.sram_dout;
    if (h_we_a)         mem_a[h_addr]        <= h_data;
    if (!ifb.sram_we_n) mem_b[ifb.sram_addr] <= ifb.sram_dout;
    if (h_we_b)         mem_b[h_addr]        <= h_data;
    if (!ifa.sram_we_n && ifa.sram_addr == DST)         t_row0 <= cyc;
    if (!ifa.sram_we_n && ifa.sram_addr == DST + 18'd4) t_row1 <= cyc;
    if (ifa.done) done_cnt_a <= done_cnt_a + 1;
    if (ifb.done) done_cnt_b <= done_cnt_b + 1;
    if (!ifb.sram_oe_n && ifb.sram_addr == KEY)         seen_k0 <= 1'b1;
    if (!ifb.sram_oe_n && ifb.sram_addr == KEY + 18'd8) seen_k1 <= 1'b1;
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] src_img [8] = '{16'h1110, 16'h1312, 16'h1514, 16'h1716,
                               16'h2120, 16'h2322, 16'h2524, 16'h2726};
  logic [15:0] rnd_key [8] = '{16'd3, 16'd6, 16'd0, 16'd5, 16'd7, 16'd1, 16'd4, 16'd2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input bit sel, input logic [17:0] a, input logic [15:0] d);
    h_addr = a;
    h_data = d;
    if (sel) h_we_b = 1'b1;
    else     h_we_a = 1'b1;
    tick();
    h_we_a = 1'b0;
    h_we_b = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (ifa.done !== 1'b1 && n < 3000) begin tick(); n++; end
    check(tag, 32'(ifa.done), 32'd1);
    tick();
  endtask

  task automatic run_a(input logic m, input string tag);
    ifa.mode  = m;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    wait_done_a(tag);
  endtask

  initial begin
    int d0;
    int n;
    ifa.start = 1'b0; ifa.mode = 1'b0;
    ifb.start = 1'b0; ifb.mode = 1'b0;
    repeat (3) tick();

    check("rst_busy",    32'(ifa.busy),         32'd0);
    check("rst_done",    32'(ifa.done),         32'd0);
    check("rst_we_n",    32'(ifa.sram_we_n),    32'd1);
    check("rst_oe_n",    32'(ifa.sram_oe_n),    32'd1);
    check("rst_dout_en", 32'(ifa.sram_dout_en), 32'd0);
    check("rst_addr",    32'(ifa.sram_addr),    32'd0);
    check("rst_dout",    32'(ifa.sram_dout),    32'd0);
    check("rst_row",     32'(ifa.row_idx),      32'd0);
    check("rst_ce_n",    32'(ifa.sram_ce_n),    32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) poke(1'b0, SRC + 18'(i), src_img[i]);
    for (int i = 0; i < 8; i++) poke(1'b0, KEY + 18'(i), 16'(i));

    // Identity key
    d0 = done_cnt_a;
    run_a(1'b0, "id_done");
    for (int i = 0; i < 8; i++) check($sformatf("id_dst%0d", i), 32'(mem_a[DST + 18'(i)]), 32'(src_img[i]));
    check("id_done_count", 32'(done_cnt_a - d0), 32'd1);
    check("row_cycles",    32'(t_row1 - t_row0), 32'd25);
    check("id_row_wrap",   32'(ifa.row_idx),     32'd0);

    // Reverse key
    for (int i = 0; i < 8; i++) poke(1'b0, KEY + 18'(i), 16'(7 - i));
    run_a(1'b0, "rev_done");
    check("rev_dst0", 32'(mem_a[DST + 18'd0]), 32'h1617);
    check("rev_dst1", 32'(mem_a[DST + 18'd1]), 32'h1415);
    check("rev_dst2", 32'(mem_a[DST + 18'd2]), 32'h1213);
    check("rev_dst3", 32'(mem_a[DST + 18'd3]), 32'h1011);
    check("rev_dst4", 32'(mem_a[DST + 18'd4]), 32'h2627);
    check("rev_dst7", 32'(mem_a[DST + 18'd7]), 32'h2021);

    // Bijective key: scramble, feed back, unscramble
    for (int i = 0; i < 8; i++) poke(1'b0, KEY + 18'(i), rnd_key[i]);
    run_a(1'b0, "rnd_fwd_done");
    check("rnd_dst0", 32'(mem_a[DST + 18'd0]), 32'h1613);
    check("rnd_dst1", 32'(mem_a[DST + 18'd1]), 32'h1510);
    check("rnd_dst2", 32'(mem_a[DST + 18'd2]), 32'h1117);
    check("rnd_dst3", 32'(mem_a[DST + 18'd3]), 32'h1214);
    check("rnd_dst4", 32'(mem_a[DST + 18'd4]), 32'h2623);
    for (int i = 0; i < 8; i++) poke(1'b0, SRC + 18'(i), mem_a[DST + 18'(i)]);
    run_a(1'b1, "rnd_inv_done");
    for (int i = 0; i < 8; i++) check($sformatf("inv_dst%0d", i), 32'(mem_a[DST + 18'(i)]), 32'(src_img[i]));
    for (int i = 0; i < 8; i++) poke(1'b0, SRC + 18'(i), src_img[i]);

    // Out-of-range key entry wraps to its low bits
    for (int i = 0; i < 8; i++) poke(1'b0, KEY + 18'(i), 16'(i));
    poke(1'b0, KEY + 18'd5, 16'hFFF9);
    run_a(1'b0, "wrap_done");
    check("wrap_dst2", 32'(mem_a[DST + 18'd2]), 32'h1114);
    check("wrap_dst0", 32'(mem_a[DST + 18'd0]), 32'h1110);
    poke(1'b0, KEY + 18'd5, 16'd5);

    // Reset in the middle of the first destination write
    for (int i = 0; i < 8; i++) poke(1'b0, DST + 18'(i), 16'h0000);
    ifa.mode = 1'b0; ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    n = 0;
    while (ifa.sram_we_n !== 1'b0 && n < 500) begin tick(); n++; end
    check("mid_reach_wr", 32'(ifa.sram_we_n), 32'd0);
    reset = 1'b1;
    tick();
    check("mid_we_n",  32'(ifa.sram_we_n), 32'd1);
    check("mid_busy",  32'(ifa.busy),      32'd0);
    check("mid_state", 32'(dut_a.state_q), 32'(S_IDLE));
    reset = 1'b0;
    tick();
    check("mid_no_wr1", 32'(mem_a[DST + 18'd1]), 32'h0000);
    run_a(1'b0, "mid_restart_done");
    for (int i = 0; i < 8; i++) check($sformatf("mid_dst%0d", i), 32'(mem_a[DST + 18'(i)]), 32'(src_img[i]));

    // Start while busy is ignored
    for (int i = 0; i < 8; i++) poke(1'b0, KEY + 18'(i), rnd_key[i]);
    d0 = done_cnt_a;
    ifa.mode = 1'b0; ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    repeat (20) tick();
    check("busy_mid_pass", 32'(ifa.busy), 32'd1);
    ifa.mode = 1'b1; ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0; ifa.mode = 1'b0;
    wait_done_a("ign_done");
    repeat (5) tick();
    check("ign_done_count", 32'(done_cnt_a - d0), 32'd1);
    check("ign_idle_busy",  32'(ifa.busy), 32'd0);
    check("ign_dst0", 32'(mem_a[DST + 18'd0]), 32'h1613);
    check("ign_dst4", 32'(mem_a[DST + 18'd4]), 32'h2623);

    // Per-row key reload on the second engine
    for (int i = 0; i < 8; i++) poke(1'b1, SRC + 18'(i), src_img[i]);
    for (int i = 0; i < 8; i++) poke(1'b1, KEY + 18'(i), 16'(7 - i));
    for (int i = 0; i < 8; i++) poke(1'b1, KEY + 18'(8 + i), 16'(i));
    d0 = done_cnt_b;
    ifb.mode = 1'b0; ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    n = 0;
    while (ifb.done !== 1'b1 && n < 3000) begin tick(); n++; end
    check("kpr_done", 32'(ifb.done), 32'd1);
    tick();
    check("kpr_done_count", 32'(done_cnt_b - d0), 32'd1);
    check("kpr_dst0", 32'(mem_b[DST + 18'd0]), 32'h1617);
    check("kpr_dst3", 32'(mem_b[DST + 18'd3]), 32'h1011);
    check("kpr_dst4", 32'(mem_b[DST + 18'd4]), 32'h2120);
    check("kpr_dst7", 32'(mem_b[DST + 18'd7]), 32'h2726);
    check("kpr_key_rd0", 32'(seen_k0), 32'd1);
    check("kpr_key_rd1", 32'(seen_k1), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
